// File: rtl/fp_add_align_if.sv
// Operand/result handshake bundle for the FP adder alignment stage.
// slave = alignment stage side, master = producer/consumer side.
interface fp_add_align_if #(
   parameter int EW = 8,
   parameter int FW = 23
);
   localparam int SW = FW + 4;
   localparam int W  = EW + FW + 1;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic          swap;
   logic          sign_big;
   logic          sign_small;
   logic [EW-1:0] e_common;
   logic [SW-1:0] m_big;
   logic [SW-1:0] m_small;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, swap, sign_big, sign_small,
             e_common, m_big, m_small
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, swap, sign_big, sign_small,
             e_common, m_big, m_small
   );
endinterface

// File: rtl/fp_add_align.sv
// FP adder front end: orders operands by magnitude and right-aligns the smaller
// significand one bit per clock, folding shifted-out bits into a sticky bit.
module fp_add_align #(
   parameter int EW = 8,
   parameter int FW = 23
) (
   input  logic            clk,
   input  logic            rst_n,
   fp_add_align_if.slave   bus
);
   localparam int SW = FW + 4;
   localparam int W  = EW + FW + 1;
   localparam logic [EW-1:0] SW_E  = EW'(SW);
   localparam logic [EW-1:0] ONE_E = EW'(1);

   typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_swap;
   logic          r_sign_big;
   logic          r_sign_small;
   logic [EW-1:0] r_e_common;
   logic [EW-1:0] r_cnt;
   logic [SW-1:0] r_m_big;
   logic [SW-1:0] r_m_small;

   logic [EW-1:0] w_exp_a, w_exp_b, w_e_a, w_e_b, w_e_big, w_e_small, w_d;
   logic [FW-1:0] w_frac_a, w_frac_b;
   logic [SW-1:0] w_m_a, w_m_b, w_m_big, w_m_small;
   logic          w_swap, w_sat;

   // Zero/denormal operands use effective exponent 1 with a clear hidden bit.
   assign w_exp_a   = r_a[W-2:FW];
   assign w_exp_b   = r_b[W-2:FW];
   assign w_frac_a  = r_a[FW-1:0];
   assign w_frac_b  = r_b[FW-1:0];
   assign w_e_a     = (w_exp_a == '0) ? ONE_E : w_exp_a;
   assign w_e_b     = (w_exp_b == '0) ? ONE_E : w_exp_b;
   assign w_m_a     = {(w_exp_a != '0), w_frac_a, 3'b000};
   assign w_m_b     = {(w_exp_b != '0), w_frac_b, 3'b000};
   assign w_swap    = (w_e_b > w_e_a) | ((w_e_b == w_e_a) & (w_frac_b > w_frac_a));
   assign w_e_big   = w_swap ? w_e_b : w_e_a;
   assign w_e_small = w_swap ? w_e_a : w_e_b;
   assign w_m_big   = w_swap ? w_m_b : w_m_a;
   assign w_m_small = w_swap ? w_m_a : w_m_b;
   assign w_d       = w_e_big - w_e_small;
   assign w_sat     = (w_d >= SW_E);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_next = COMPARE;
         COMPARE: w_next = ((w_d == '0) || w_sat) ? DONE : SHIFT;
         SHIFT:   if (r_cnt == ONE_E) w_next = DONE;
         DONE:    if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_swap       <= 1'b0;
         r_sign_big   <= 1'b0;
         r_sign_small <= 1'b0;
         r_e_common   <= '0;
         r_cnt        <= '0;
         r_m_big      <= '0;
         r_m_small    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a <= bus.a;
                  r_b <= bus.b;
               end
            end
            COMPARE: begin
               r_swap       <= w_swap;
               r_sign_big   <= w_swap ? r_b[W-1] : r_a[W-1];
               r_sign_small <= w_swap ? r_a[W-1] : r_b[W-1];
               r_e_common   <= w_e_big;
               r_m_big      <= w_m_big;
               r_m_small    <= w_sat ? {{(SW-1){1'b0}}, |w_m_small} : w_m_small;
               r_cnt        <= w_d;
            end
            SHIFT: begin
               r_m_small <= {1'b0, r_m_small[SW-1:2], |r_m_small[1:0]};
               r_cnt     <= r_cnt - ONE_E;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == IDLE);
   assign bus.out_valid  = (r_state == DONE);
   assign bus.swap       = r_swap;
   assign bus.sign_big   = r_sign_big;
   assign bus.sign_small = r_sign_small;
   assign bus.e_common   = r_e_common;
   assign bus.m_big      = r_m_big;
   assign bus.m_small    = r_m_small;
endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: directed cases, boundaries, backpressure,
// mid-shift reset and a few random operand pairs.
module tb_fp_add_align;
   logic clk;
   logic rst_n;

   fp_add_align_if #(.EW(8), .FW(23)) bus ();

   fp_add_align #(.EW(8), .FW(23)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sw;
      logic        sb;
      logic        ss;
      logic [7:0]  e;
      logic [26:0] mb;
      logic [26:0] ms;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Closed-form alignment: exact shift plus OR of every discarded bit.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        r;
      int          ea, eb, d;
      logic [26:0] ma, mb, msm, tmp;
      logic [31:0] mask;
      ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
      ma = {(a[30:23] != 0), a[22:0], 3'b000};
      mb = {(b[30:23] != 0), b[22:0], 3'b000};
      r.sw = (eb > ea) || ((eb == ea) && (b[22:0] > a[22:0]));
      r.sb = r.sw ? b[31] : a[31];
      r.ss = r.sw ? a[31] : b[31];
      r.e  = r.sw ? 8'(eb) : 8'(ea);
      r.mb = r.sw ? mb : ma;
      msm  = r.sw ? ma : mb;
      d    = r.sw ? (eb - ea) : (ea - eb);
      if (d == 0) begin
         r.ms  = msm;
         r.lat = 2;
      end else if (d >= 27) begin
         r.ms  = {26'b0, |msm};
         r.lat = 2;
      end else begin
         tmp   = msm >> d;
         mask  = (32'd1 << (d + 1)) - 32'd1;
         r.ms  = {tmp[26:1], |({5'b0, msm} & mask)};
         r.lat = 2 + d;
      end
      return r;
   endfunction

   task automatic check_result(input string tag, input exp_t e);
      check({tag, ".out_valid"},  {31'b0, bus.out_valid}, 32'd1);
      check({tag, ".swap"},       {31'b0, bus.swap}, {31'b0, e.sw});
      check({tag, ".sign_big"},   {31'b0, bus.sign_big}, {31'b0, e.sb});
      check({tag, ".sign_small"}, {31'b0, bus.sign_small}, {31'b0, e.ss});
      check({tag, ".e_common"},   {24'b0, bus.e_common}, {24'b0, e.e});
      check({tag, ".m_big"},      {5'b0, bus.m_big}, {5'b0, e.mb});
      check({tag, ".m_small"},    {5'b0, bus.m_small}, {5'b0, e.ms});
      check({tag, ".in_ready"},   {31'b0, bus.in_ready}, 32'd0);
   endtask

   // hold = cycles of out_ready=0 once the result is visible.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      exp_t e;
      int   lat;
      q.push_back(model(a, b));
      @(posedge clk); #1;
      check({tag, ".in_ready_idle"}, {31'b0, bus.in_ready}, 32'd1);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      e = q.pop_front();
      check({tag, ".latency"}, lat, e.lat);
      check_result(tag, e);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = i[0];
         bus.a = 32'h7F000000;
         bus.b = 32'h00000001;
         @(posedge clk); #1;
         check_result({tag, ".hold"}, e);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".ready_after"}, {31'b0, bus.in_ready}, 32'd1);
      check({tag, ".valid_after"}, {31'b0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      rst_n         = 1'b0;
      #1;
      check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst.m_small",   {5'b0, bus.m_small}, 32'd0);
      check("rst.e_common",  {24'b0, bus.e_common}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);

      run_op("one_vs_1p5",  32'h3F800000, 32'h3FC00000, 0);
      run_op("four_vs_m1",  32'h40800000, 32'hBF800000, 0);
      run_op("sat_sticky",  32'h3F800001, 32'h4E800000, 0);
      run_op("sat_zero",    32'h3F800000, 32'h00000000, 0);
      run_op("equal",       32'h3F800000, 32'h3F800000, 0);
      run_op("d26",         32'h3F800001, 32'h4C800000, 0);
      run_op("d27",         32'h3F800001, 32'h4D000000, 0);
      run_op("denorm_pair", 32'h00000005, 32'h80000003, 0);
      run_op("backpress",   32'h40800000, 32'hBF800000, 5);

      // Abort a d=3 operation during its second shift cycle.
      @(posedge clk); #1;
      bus.a = 32'h41000000;
      bus.b = 32'h3F800000;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort.out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("abort.m_small",   {5'b0, bus.m_small}, 32'd0);
      check("abort.m_big",     {5'b0, bus.m_big}, 32'd0);
      check("abort.e_common",  {24'b0, bus.e_common}, 32'd0);
      check("abort.flags",     {29'b0, bus.swap, bus.sign_big, bus.sign_small}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("abort.no_valid", {31'b0, bus.out_valid}, 32'd0);
      end
      check("abort.in_ready", {31'b0, bus.in_ready}, 32'd1);
      run_op("after_abort", 32'h41000000, 32'h3F800000, 0);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = {$urandom_range(1, 0) == 1, 8'(ra[30:23] + 8'($urandom_range(12, 0))),
               23'($urandom)};
         run_op("random", ra, rb, i % 2);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Front-end alignment stage of the floating-point adder, the input-side counterpart of the back-end exponent/normalisation fix-up.
- Accepts two IEEE-754 single-precision operands and orders them by magnitude.
- Shifts the smaller significand right, one bit per clock, until its exponent matches the larger operand's, with guard/round/sticky tracking.
- Presents both aligned significands, the common exponent and signs to the mantissa adder over a valid/ready handshake.

Parameters:
- EW, 8, exponent width.
- FW, 23, stored fraction width. Working significand width is SW = FW+4 (hidden bit + fraction + guard, round, sticky) = 27.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  EW+FW+1  operand A, IEEE format.
- b  input  EW+FW+1  operand B, IEEE format.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- swap  output  1  1 = B had the larger magnitude.
- sign_big  output  1  sign of the larger-magnitude operand.
- sign_small  output  1  sign of the smaller-magnitude operand.
- e_common  output  EW  biased exponent of the larger operand (effective exponent, see below).
- m_big  output  SW  larger significand: {hidden, fraction, 3'b000}.
- m_small  output  SW  smaller significand, right-shifted, sticky in bit 0.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs and internal registers go to 0; in_ready=1 once reset releases.
- FSM states: IDLE, COMPARE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid & in_ready, register a and b, then go to COMPARE.
- Operand unpacking:
  - exponent==0 means hidden bit 0 and effective exponent 1 (zero/denormal).
  - Otherwise hidden bit 1 and effective exponent = exponent.
  - NaN/Inf get no special handling; they are unpacked the same way.
- COMPARE:
  - swap = (eB>eA) | (eB==eA & fracB>fracA). Equal magnitudes give swap=0.
  - Load m_big and m_small from the ordered operands, each {hidden, frac, 000}.
  - Load e_common = larger effective exponent and d = eBig - eSmall (unsigned, EW bits).
  - If d==0: go to DONE.
  - If d>=SW: saturate in the same cycle, m_small = {SW-1 zeros, |m_small}, then go to DONE.
  - Else: load a shift counter with d and go to SHIFT.
- SHIFT, once per cycle:
  - m_small <= {0, m_small[SW-1:2], m_small[1]|m_small[0]}; counter decrements.
  - When the counter reaches 1, go to DONE after that shift, so exactly d shifts are performed.
- DONE:
  - Outputs are held stable while out_ready=0.
  - On out_ready, go to IDLE.
  - in_valid is ignored outside IDLE.
- Latency: with acceptance on edge 0, out_valid rises after edge 2+k, where k=d for 0<d<SW and k=0 otherwise. Maximum 2+SW-1 = 28 cycles.
- Throughput: one operation at a time, no overlap. A new accept is possible in the cycle after the DONE handshake.
- Reset asserted mid-operation aborts immediately. No partial result is emitted after reset release.

Test Plan:
- a=0x3F800000 (1.0), b=0x3FC00000 (1.5), accept at cycle 0, out_ready=1 -> out_valid at cycle 2, swap=1, e_common=127, m_big=0x6000000, m_small=0x4000000, sign_big=sign_small=0.
- a=0x40800000 (4.0), b=0xBF800000 (-1.0) -> d=2, out_valid at cycle 4, swap=0, e_common=129, m_big=0x4000000, m_small=0x1000000, sign_big=0, sign_small=1.
- a=0x3F800001, b=0x4E800000 (2^30) -> d=30 saturates, out_valid at cycle 2, swap=1, e_common=157, m_small=0x0000001 (sticky); the same case with b=0x00000000 against a=0x3F800000 gives m_small=0x0000000.
- a=0x3F800000, b=0x3F800000 -> swap=0, m_big=m_small=0x4000000, out_valid at cycle 2.
- Backpressure: the d=2 case with out_ready held 0 for 5 cycles -> outputs stable and in_ready=0 throughout; in_valid pulses during that time are ignored; after out_ready, in_ready=1 the next cycle.
- Reset mid-SHIFT: a=0x41000000 (8.0), b=0x3F800000 (d=3); drop rst_n during the 2nd SHIFT cycle -> all outputs 0 immediately, out_valid never asserts for that op; after release, in_ready=1 and a fresh op completes correctly.
